// File: rtl/hlsm_seq_alu.sv
// Multi-cycle HLSM computing z = a*b + c and x = |z - a| with one shared multiplier and adder.
// Define HLSM_PIPE_MULT_EN to split the multiply into two registered half-width stages (latency 6).
module hlsm_seq_alu #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 Done,
    output logic [DATAWIDTH-1:0] z,
    output logic [DATAWIDTH-1:0] x
);

`ifdef HLSM_PIPE_MULT_EN
    localparam int HALF = DATAWIDTH / 2;

    typedef enum logic [2:0] {
        ST_WAIT, ST_S1A, ST_S1B, ST_S2, ST_S3, ST_S4, ST_FINAL
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_WAIT, ST_S1, ST_S2, ST_S3, ST_S4, ST_FINAL
    } state_t;
`endif

    state_t               state_q;
    logic [DATAWIDTH-1:0] ra_q;
    logic [DATAWIDTH-1:0] rb_q;
    logic [DATAWIDTH-1:0] rc_q;
    logic [DATAWIDTH-1:0] t1_q;
    logic [DATAWIDTH-1:0] t2_q;
    logic                 gt_q;
    logic                 done_q;
    logic [DATAWIDTH-1:0] z_q;
    logic [DATAWIDTH-1:0] x_q;
`ifdef HLSM_PIPE_MULT_EN
    logic [DATAWIDTH-1:0] pp_lo_q;
    logic [DATAWIDTH-1:0] pp_hi_q;
`endif

    logic [DATAWIDTH-1:0] add_a_s;
    logic [DATAWIDTH-1:0] add_b_s;
    logic                 add_sub_s;
    logic [DATAWIDTH-1:0] add_res_s;

    // Operand steering for the single shared adder/subtractor.
    always_comb begin
        add_a_s   = t1_q;
        add_b_s   = rc_q;
        add_sub_s = 1'b0;
        case (state_q)
`ifdef HLSM_PIPE_MULT_EN
            ST_S1B: begin
                add_a_s   = pp_lo_q;
                add_b_s   = pp_hi_q << HALF;
                add_sub_s = 1'b0;
            end
`endif
            ST_S4: begin
                add_sub_s = 1'b1;
                if (gt_q) begin
                    add_a_s = t2_q;
                    add_b_s = ra_q;
                end else begin
                    add_a_s = ra_q;
                    add_b_s = t2_q;
                end
            end
            default: begin
                add_a_s   = t1_q;
                add_b_s   = rc_q;
                add_sub_s = 1'b0;
            end
        endcase
    end

    // Subtraction as a + ~b + 1 keeps a single carry chain for both operations.
    assign add_res_s = add_a_s + (add_sub_s ? ~add_b_s : add_b_s)
                       + {{(DATAWIDTH-1){1'b0}}, add_sub_s};

    // Schedule FSM with registered results and a Done pulse registered from FINAL.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_WAIT;
            ra_q    <= {DATAWIDTH{1'b0}};
            rb_q    <= {DATAWIDTH{1'b0}};
            rc_q    <= {DATAWIDTH{1'b0}};
            t1_q    <= {DATAWIDTH{1'b0}};
            t2_q    <= {DATAWIDTH{1'b0}};
            gt_q    <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= {DATAWIDTH{1'b0}};
            x_q     <= {DATAWIDTH{1'b0}};
`ifdef HLSM_PIPE_MULT_EN
            pp_lo_q <= {DATAWIDTH{1'b0}};
            pp_hi_q <= {DATAWIDTH{1'b0}};
`endif
        end else begin
            done_q <= (state_q == ST_FINAL);
            case (state_q)
                ST_WAIT: begin
                    if (Start) begin
                        ra_q    <= a;
                        rb_q    <= b;
                        rc_q    <= c;
`ifdef HLSM_PIPE_MULT_EN
                        state_q <= ST_S1A;
`else
                        state_q <= ST_S1;
`endif
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
`ifdef HLSM_PIPE_MULT_EN
                // Low DATAWIDTH bits only matter, so rb halves are treated as unsigned.
                ST_S1A: begin
                    pp_lo_q <= ra_q * {{(DATAWIDTH-HALF){1'b0}}, rb_q[HALF-1:0]};
                    pp_hi_q <= ra_q * {{HALF{1'b0}}, rb_q[DATAWIDTH-1:HALF]};
                    state_q <= ST_S1B;
                end
                ST_S1B: begin
                    t1_q    <= add_res_s;
                    state_q <= ST_S2;
                end
`else
                ST_S1: begin
                    t1_q    <= ra_q * rb_q;
                    state_q <= ST_S2;
                end
`endif
                ST_S2: begin
                    t2_q    <= add_res_s;
                    state_q <= ST_S3;
                end
                ST_S3: begin
                    z_q     <= t2_q;
                    gt_q    <= ($signed(t2_q) > $signed(ra_q));
                    state_q <= ST_S4;
                end
                ST_S4: begin
                    x_q     <= add_res_s;
                    state_q <= ST_FINAL;
                end
                ST_FINAL: begin
                    state_q <= ST_WAIT;
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    assign Done = done_q;
    assign z    = z_q;
    assign x    = x_q;

endmodule
